// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the round-robin dispatcher and its pick logic.
package dispatch_pkg;

    localparam int unsigned DEF_N     = 8;
    localparam int unsigned DEF_W     = 8;
    localparam int unsigned DEF_DEPTH = 2;

    // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned CW = clog2(DEF_DEPTH) + 1;

    // Rotate the low n bits of v left by one position; bits at or above n are cleared.
    function automatic logic [31:0] rotl1(input logic [31:0] v, input int unsigned n);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n) begin
                r[5'((i + 1) % n)] = v[5'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dispatch_pick.sv
// Cyclic first-one picker: lowest set bit of elig at or after the one-hot ptr, wrapping.
module dispatch_pick #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] elig,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] sel
);

    localparam int unsigned DW = 2 * N;

    logic [DW-1:0] dbl;
    logic [DW-1:0] first;

    // Lower copy keeps only bits at or above ptr; upper copy supplies the wrap-around.
    always_comb begin
        dbl   = {elig, elig & ~(ptr - N'(1))};
        first = dbl & (~dbl + DW'(1));
        sel   = first[N-1:0] | first[DW-1:N];
    end

endmodule

// File: rtl/dispatch_rr.sv
// Round-robin dispatcher: upstream req/ack into a small FIFO, each word issued to one target.
module dispatch_rr
    import dispatch_pkg::*;
#(
    parameter  int unsigned N     = DEF_N,
    parameter  int unsigned W     = DEF_W,
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned CNT_W = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_i,
    output logic             ack_i,
    input  logic [W-1:0]     data_i,
    output logic [N-1:0]     req_o,
    input  logic [N-1:0]     ack_o,
    output logic [W-1:0]     data_o,
    input  logic [N-1:0]     en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             idle_o
);

    localparam int unsigned AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic [N-1:0]     ptr;
    logic             ready;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [N-1:0]     elig;
    logic [N-1:0]     sel;

    // Upstream accept depends only on registered state, never on req_i.
    always_comb begin
        full  = (count == CNT_W'(DEPTH));
        empty = (count == '0);
        ack_i = ready & ~full;
        push  = req_i & ack_i;
        elig  = ack_o & en_i & {N{~empty}};
        pop   = |sel;
    end

    dispatch_pick #(
        .N (N)
    ) u_pick (
        .elig (elig),
        .ptr  (ptr),
        .sel  (sel)
    );

    // Pointers, occupancy, rotating priority and the post-reset ready flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ptr    <= N'(1);
            ready  <= 1'b0;
        end else begin
            ready <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                ptr    <= N'(rotl1(32'(sel), N));
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_comb begin
        req_o   = sel;
        data_o  = mem[rd_ptr];
        count_o = count;
        idle_o  = empty;
    end

endmodule

// File: tb/tb_dispatch_rr.sv
// Scoreboard bench for dispatch_rr: directed scenarios plus randomized traffic vs a queue model.
module tb_dispatch_rr;

    localparam int N = 8;
    localparam int W = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rstn;
    logic             req_i;
    logic             ack_i;
    logic [W-1:0]     data_i;
    logic [N-1:0]     req_o;
    logic [N-1:0]     ack_o;
    logic [W-1:0]     data_o;
    logic [N-1:0]     en_i;
    logic [CNT_W-1:0] count_o;
    logic             idle_o;

    dispatch_rr #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req_i   (req_i),
        .ack_i   (ack_i),
        .data_i  (data_i),
        .req_o   (req_o),
        .ack_o   (ack_o),
        .data_o  (data_o),
        .en_i    (en_i),
        .count_o (count_o),
        .idle_o  (idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    int mptr = 0;
    logic [W-1:0] exp_q[$];
    int log_d[$];
    int log_t[$];
    int log_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int lg_t(input int i);
        return (i < log_t.size()) ? log_t[i] : -1;
    endfunction

    function automatic int lg_d(input int i);
        return (i < log_d.size()) ? log_d[i] : -1;
    endfunction

    function automatic int lg_c(input int i);
        return (i < log_c.size()) ? log_c[i] : -1;
    endfunction

    // Monitor: the model picks the first ready+enabled target from its pointer, cyclically.
    always @(negedge clk) begin : monitor
        int t;
        int sz;
        if (rstn) begin
            t = -1;
            sz = exp_q.size();
            if (sz > 0) begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (mptr + i) % N;
                    if (ack_o[k] && en_i[k]) begin
                        t = k;
                        break;
                    end
                end
            end
            chk("count_o", count_o, sz);
            chk("idle_o", idle_o, (sz == 0) ? 1 : 0);
            chk("req_o_en_mask", req_o & ~en_i, 0);
            if (t < 0) begin
                chk("req_o_none", req_o, 0);
            end else begin
                chk("req_o_target", req_o, longint'(1) << t);
                chk("data_o", data_o, exp_q[0]);
                log_d.push_back(int'(exp_q[0]));
                log_t.push_back(t);
                log_c.push_back(cyc);
                void'(exp_q.pop_front());
                mptr = (t + 1) % N;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer one word; the expected word enters the scoreboard on the edge that accepts it.
    task automatic send(input logic [W-1:0] d, output int pc);
        bit ok;
        ok = 0;
        pc = -1;
        req_i = 1'b1;
        data_i = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ack_i) begin
                ok = 1;
                pc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            chk("send_timeout", 0, 1);
            req_i = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(d);
            #1;
            req_i = 1'b0;
        end
    endtask

    task automatic send1(input logic [W-1:0] d);
        int pc;
        send(d, pc);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int pc0;
        int pc;
        int b;
        bit done;
        rstn = 1'b0;
        req_i = 1'b0;
        data_i = '0;
        ack_o = 8'hFF;
        en_i = 8'hFF;

        // Reset state and ready release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack_i", ack_i, 0);
        chk("rst_count", count_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_req_o", req_o, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        chk("ack_i_before_edge", ack_i, 0);
        @(posedge clk);
        #1;
        chk("ack_i_after_release", ack_i, 1);

        // Back-to-back words go 0..7 at one per cycle
        b = log_t.size();
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h10 + i), pc);
            if (i == 0) pc0 = pc;
        end
        drain();
        for (int i = 0; i < 8; i++) begin
            chk("rr_target", lg_t(b + i), i);
            chk("rr_data", lg_d(b + i), 8'h10 + i);
        end
        chk("first_latency", lg_c(b), pc0 + 1);
        chk("steady_rate", lg_c(b + 7) - lg_c(b), 7);

        // Stall with all targets busy: FIFO fills, then target 2 takes the head
        ack_o = 8'h00;
        b = log_t.size();
        done = 0;
        fork
            begin
                send1(8'h20);
                send1(8'h21);
                send1(8'h22);
                done = 1;
            end
        join_none
        repeat (4) tick();
        chk("full_count", count_o, 2);
        chk("full_ack_i", ack_i, 0);
        @(posedge clk);
        #1;
        ack_o = 8'h04;
        tick();
        chk("stall_target", lg_t(b), 2);
        chk("stall_data", lg_d(b), 8'h20);
        tick();
        chk("after_pop_count", count_o, 1);
        chk("after_pop_ack_i", ack_i, 1);
        for (int n = 0; n < 50 && !done; n++) tick();
        chk("stall_sends_done", done, 1);
        drain();
        ack_o = 8'hFF;

        // Pointer after a target-5 transfer, then wrap to target 0
        ack_o = 8'h20; send1(8'h30); drain();
        b = log_t.size();
        ack_o = 8'h41; send1(8'h31); drain();
        chk("ptr6_target", lg_t(b), 6);
        ack_o = 8'h20; send1(8'h32); drain();
        b = log_t.size();
        ack_o = 8'h01; send1(8'h33); drain();
        chk("wrap_target", lg_t(b), 0);

        // Only targets 1 and 3 enabled
        en_i = 8'h0A;
        ack_o = 8'hFF;
        b = log_t.size();
        for (int i = 0; i < 4; i++) send1(8'(8'h40 + i));
        drain();
        chk("en_t0", lg_t(b), 1);
        chk("en_t1", lg_t(b + 1), 3);
        chk("en_t2", lg_t(b + 2), 1);
        chk("en_t3", lg_t(b + 3), 3);
        en_i = 8'hFF;

        // Reset while full drops the words immediately
        ack_o = 8'h00;
        send1(8'h60);
        send1(8'h61);
        tick();
        chk("pre_reset_count", count_o, 2);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        ack_o = 8'hFF;
        #1;
        chk("mid_reset_count", count_o, 0);
        chk("mid_reset_idle", idle_o, 1);
        chk("mid_reset_req_o", req_o, 0);
        chk("mid_reset_ack_i", ack_i, 0);
        exp_q.delete();
        mptr = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) tick();
        @(posedge clk);
        #1;

        // Simultaneous push and pop at count 1
        ack_o = 8'h00;
        b = log_t.size();
        send1(8'h50);
        chk("one_count", count_o, 1);
        ack_o = 8'hFF;
        send1(8'h51);
        tick();
        chk("pushpop_count", count_o, 1);
        drain();
        chk("pushpop_order0", lg_d(b), 8'h50);
        chk("pushpop_order1", lg_d(b + 1), 8'h51);

        // Randomized traffic
        done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send1(8'($urandom));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ack_o = 8'($urandom);
                    en_i = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                end
            end
        join
        ack_o = 8'hFF;
        en_i = 8'hFF;
        drain();
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
